// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC and runs one outstanding variable-latency IMem request, with a 1-entry skid for stalls.
// InstrF/PCF/ValidF are registered (first valid 2 edges after reset); define FETCH_PERF_CNT_EN for fetch/bubble counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'hC000_0000,
  parameter logic [31:0] PC_STEP   = 32'd4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        StallF,
  input  logic        FlushF,
  input  logic        BranchTakenE,
  input  logic [31:0] BranchTargetE,
  output logic        IMemReq,
  output logic [31:0] IMemAddr,
  input  logic [31:0] IMemRData,
  input  logic        IMemValid,
  output logic [31:0] InstrF,
  output logic [31:0] PCF,
  output logic [31:0] PCPlus4F,
  output logic        ValidF
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] FetchCount,
  output logic [31:0] BubbleCount
`endif
);
  typedef enum logic [1:0] {S_RESET, S_REQ, S_HOLD, S_DROP} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] drop_addr, drop_addr_nxt;
  logic [31:0] skid_instr, skid_pc;
  logic        skid_load;
  logic        out_load, out_vld_nxt;
  logic [31:0] out_instr_nxt, out_pc_nxt;

  assign IMemReq  = (state == S_REQ) || (state == S_DROP);
  // While discarding, the address must stay on the abandoned request even though pc already holds the target.
  assign IMemAddr = {((state == S_DROP) ? drop_addr[31:2] : pc[31:2]), 2'b00};
  assign PCPlus4F = PCF + PC_STEP;

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    drop_addr_nxt = drop_addr;
    skid_load     = 1'b0;
    out_load      = 1'b1;
    out_instr_nxt = NOP_INSTR;
    out_pc_nxt    = PCF;
    out_vld_nxt   = 1'b0;
    if (BranchTakenE) begin
      pc_nxt = {BranchTargetE[31:2], 2'b00};
      if (IMemReq && !IMemValid) begin
        state_nxt = S_DROP;
        if (state == S_REQ) drop_addr_nxt = pc;
      end else begin
        state_nxt = S_REQ;
      end
    end else begin
      case (state)
        S_RESET: state_nxt = S_REQ;
        S_REQ: begin
          if (IMemValid) begin
            pc_nxt = pc + PC_STEP;
            if (StallF) begin
              skid_load = 1'b1;
              state_nxt = S_HOLD;
            end else begin
              out_instr_nxt = IMemRData;
              out_pc_nxt    = pc;
              out_vld_nxt   = 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (!StallF) begin
            state_nxt     = S_REQ;
            out_instr_nxt = skid_instr;
            out_pc_nxt    = skid_pc;
            out_vld_nxt   = 1'b1;
          end
        end
        S_DROP: if (IMemValid) state_nxt = S_REQ;
        default: state_nxt = S_RESET;
      endcase
    end
    // Flush beats stall on the output register only; the state/skid decisions above still follow StallF.
    if (FlushF) begin
      out_instr_nxt = NOP_INSTR;
      out_pc_nxt    = PCF;
      out_vld_nxt   = 1'b0;
    end else if (StallF) begin
      out_load = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= S_RESET;
      pc         <= RESET_PC;
      drop_addr  <= RESET_PC;
      skid_instr <= NOP_INSTR;
      skid_pc    <= RESET_PC;
      InstrF     <= NOP_INSTR;
      PCF        <= RESET_PC;
      ValidF     <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      drop_addr <= drop_addr_nxt;
      if (skid_load) begin
        skid_instr <= IMemRData;
        skid_pc    <= pc;
      end
      if (out_load) begin
        InstrF <= out_instr_nxt;
        PCF    <= out_pc_nxt;
        ValidF <= out_vld_nxt;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (!RST) begin
      FetchCount  <= 32'd0;
      BubbleCount <= 32'd0;
    end else if (out_load) begin
      if (out_vld_nxt) begin
        if (FetchCount != 32'hFFFF_FFFF) FetchCount <= FetchCount + 32'd1;
      end else if (BubbleCount != 32'hFFFF_FFFF) begin
        BubbleCount <= BubbleCount + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: random stall/flush/redirect/latency traffic against a flag-based fetch model, plus literal anchors.
module tb_fetch_unit;
  localparam logic [31:0] NOP = 32'hC000_0000;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        StallF = 1'b0, FlushF = 1'b0, BranchTakenE = 1'b0;
  logic [31:0] BranchTargetE = 32'h0;
  logic [31:0] IMemRData = 32'h0;
  logic        IMemValid = 1'b0;
  wire         IMemReq, ValidF;
  wire  [31:0] IMemAddr, InstrF, PCF, PCPlus4F;

  logic        RST2 = 1'b0;
  wire         IMemReq2, ValidF2;
  wire  [31:0] IMemAddr2, InstrF2, PCF2, PCPlus4F2;
`ifdef FETCH_PERF_CNT_EN
  wire  [31:0] FetchCount, BubbleCount, FetchCount2, BubbleCount2;
`endif

  always #5 CLK = ~CLK;

  fetch_unit dut (
    .CLK(CLK), .RST(RST), .StallF(StallF), .FlushF(FlushF),
    .BranchTakenE(BranchTakenE), .BranchTargetE(BranchTargetE),
    .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemRData(IMemRData), .IMemValid(IMemValid),
    .InstrF(InstrF), .PCF(PCF), .PCPlus4F(PCPlus4F), .ValidF(ValidF)
`ifdef FETCH_PERF_CNT_EN
    , .FetchCount(FetchCount), .BubbleCount(BubbleCount)
`endif
  );

  // Second instance: wrap-around reset PC with a zero-wait memory returning word = address.
  fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
    .CLK(CLK), .RST(RST2), .StallF(1'b0), .FlushF(1'b0),
    .BranchTakenE(1'b0), .BranchTargetE(32'h0),
    .IMemReq(IMemReq2), .IMemAddr(IMemAddr2), .IMemRData(IMemAddr2), .IMemValid(IMemReq2),
    .InstrF(InstrF2), .PCF(PCF2), .PCPlus4F(PCPlus4F2), .ValidF(ValidF2)
`ifdef FETCH_PERF_CNT_EN
    , .FetchCount(FetchCount2), .BubbleCount(BubbleCount2)
`endif
  );

  // Reference model: what the fetch stage has committed to, expressed as plain flags.
  bit          m_boot, m_skid_full, m_disc;
  logic [31:0] m_pc, m_drop_addr, m_skid_instr, m_skid_pc;
  logic [31:0] m_instr, m_pcf;
  bit          m_vld;
  logic [31:0] m_fcnt, m_bcnt;

  // Memory responder state.
  bit          busy, prev_hs, prev_rst;
  int unsigned cnt;
  logic [31:0] mem_xor = 32'h0;

  // Literal anchors consumed by the compare process at the next negedge.
  bit          run = 1'b0;
  bit          lit_on = 1'b0, lit2_on = 1'b0;
  string       lit_name = "", lit2_name = "";
  logic [31:0] lit_instr, lit_pc, lit_addr, lit2_instr, lit2_pc, lit2_p4;
  bit          lit_v, lit_req, lit2_v;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (run) begin
      chk("InstrF", InstrF, m_instr);
      chk("PCF", PCF, m_pcf);
      chk("ValidF", 32'(ValidF), 32'(m_vld));
      chk("PCPlus4F", PCPlus4F, m_pcf + 32'd4);
      chk("IMemReq", 32'(IMemReq), 32'(!m_boot && !m_skid_full));
      if (!m_boot && !m_skid_full) chk("IMemAddr", IMemAddr, m_disc ? m_drop_addr : m_pc);
`ifdef FETCH_PERF_CNT_EN
      chk("FetchCount", FetchCount, m_fcnt);
      chk("BubbleCount", BubbleCount, m_bcnt);
`endif
      if (lit_on) begin
        chk({lit_name, ".InstrF"}, InstrF, lit_instr);
        chk({lit_name, ".PCF"}, PCF, lit_pc);
        chk({lit_name, ".ValidF"}, 32'(ValidF), 32'(lit_v));
        chk({lit_name, ".IMemReq"}, 32'(IMemReq), 32'(lit_req));
        if (lit_req) chk({lit_name, ".IMemAddr"}, IMemAddr, lit_addr);
        chk({lit_name, ".model_PCF"}, m_pcf, lit_pc);
        chk({lit_name, ".model_InstrF"}, m_instr, lit_instr);
      end
      if (lit2_on) begin
        chk({lit2_name, ".InstrF"}, InstrF2, lit2_instr);
        chk({lit2_name, ".PCF"}, PCF2, lit2_pc);
        chk({lit2_name, ".ValidF"}, 32'(ValidF2), 32'(lit2_v));
        chk({lit2_name, ".PCPlus4F"}, PCPlus4F2, lit2_p4);
      end
    end
  end

  task automatic model_step();
    bit req, resp, ld, lv;
    logic [31:0] li, lp;
    if (!RST) begin
      m_boot = 1; m_skid_full = 0; m_disc = 0;
      m_pc = 32'h0; m_drop_addr = 32'h0;
      m_instr = NOP; m_pcf = 32'h0; m_vld = 0;
      m_fcnt = 32'h0; m_bcnt = 32'h0;
      return;
    end
    req  = !m_boot && !m_skid_full;
    resp = req && IMemValid;
    ld = 1; li = NOP; lp = m_pcf; lv = 0;
    if (FlushF) ld = 1;
    else if (StallF) ld = 0;
    else if (!BranchTakenE && resp && !m_disc) begin li = IMemRData; lp = m_pc; lv = 1; end
    else if (!BranchTakenE && m_skid_full) begin li = m_skid_instr; lp = m_skid_pc; lv = 1; end
    if (BranchTakenE) begin
      if (req && !IMemValid) begin
        if (!m_disc) m_drop_addr = m_pc;
        m_disc = 1;
      end else begin
        m_disc = 0;
      end
      m_skid_full = 0;
      m_pc = BranchTargetE & 32'hFFFF_FFFC;
    end else if (resp && m_disc) begin
      m_disc = 0;
    end else if (resp) begin
      if (StallF) begin
        m_skid_full = 1; m_skid_instr = IMemRData; m_skid_pc = m_pc;
      end
      m_pc = m_pc + 32'd4;
    end else if (m_skid_full && !StallF) begin
      m_skid_full = 0;
    end
    m_boot = 0;
    if (ld) begin
      m_instr = li; m_pcf = lp; m_vld = lv;
      if (lv) begin if (m_fcnt != 32'hFFFF_FFFF) m_fcnt++; end
      else if (m_bcnt != 32'hFFFF_FFFF) m_bcnt++;
    end
  endtask

  // One clock: drive inputs after the edge, let memory answer, advance the model after the negedge compare.
  task automatic step(input bit rst, input bit stall, input bit flush, input bit br,
                      input logic [31:0] tgt, input int unsigned wt);
    @(posedge CLK); #1;
    if (!prev_rst || prev_hs) busy = 0;
    else if (busy && cnt > 0) cnt--;
    RST = rst; StallF = stall; FlushF = flush; BranchTakenE = br; BranchTargetE = tgt;
    if (rst && IMemReq && !busy) begin busy = 1; cnt = wt; end
    IMemValid = rst && busy && IMemReq && (cnt == 0);
    IMemRData = IMemAddr ^ mem_xor;
    @(negedge CLK); #1;
    prev_hs  = IMemValid && IMemReq;
    prev_rst = rst;
    model_step();
    lit_on = 0; lit2_on = 0;
  endtask

  task automatic want(input string nm, input logic [31:0] i, input logic [31:0] p, input bit v,
                      input bit rq, input logic [31:0] a);
    lit_on = 1; lit_name = nm; lit_instr = i; lit_pc = p; lit_v = v; lit_req = rq; lit_addr = a;
  endtask

  task automatic want2(input string nm, input logic [31:0] i, input logic [31:0] p, input bit v);
    lit2_on = 1; lit2_name = nm; lit2_instr = i; lit2_pc = p; lit2_v = v; lit2_p4 = p + 32'd4;
  endtask

  initial begin
    busy = 0; prev_hs = 0; prev_rst = 0; cnt = 0;
    step(0, 0, 0, 0, 32'h0, 0);
    run = 1;
    step(0, 0, 0, 0, 32'h0, 0);  want("rst", NOP, 32'h0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 32'h0, 0);  want("boot", NOP, 32'h0, 0, 1, 32'h0);
    step(1, 0, 0, 0, 32'h0, 0);  want("f0", 32'h0, 32'h0, 1, 1, 32'h4);
    step(1, 0, 0, 0, 32'h0, 0);  want("f4", 32'h4, 32'h4, 1, 1, 32'h8);
    step(1, 0, 0, 0, 32'h0, 0);  want("f8", 32'h8, 32'h8, 1, 1, 32'hC);
    step(1, 0, 0, 0, 32'h0, 0);  want("fC", 32'hC, 32'hC, 1, 1, 32'h10);
    // Redirect while the request to 0x10 waits one more cycle.
    step(1, 0, 1, 1, 32'h103, 1); want("br_drop", NOP, 32'hC, 0, 1, 32'h10);
    step(1, 0, 0, 0, 32'h0, 0);  want("br_disc", NOP, 32'hC, 0, 1, 32'h100);
    step(1, 0, 0, 0, 32'h0, 0);  want("br_first", 32'h100, 32'h100, 1, 1, 32'h104);
    step(1, 0, 0, 0, 32'h0, 2);  want("lat_b1", NOP, 32'h100, 0, 1, 32'h104);
    step(1, 0, 0, 0, 32'h0, 0);  want("lat_b2", NOP, 32'h100, 0, 1, 32'h104);
    step(1, 0, 0, 0, 32'h0, 0);  want("lat_v", 32'h104, 32'h104, 1, 1, 32'h108);
    for (int k = 0; k < 5; k++) begin
      step(1, 1, 0, 0, 32'h0, 0); want("stall", 32'h104, 32'h104, 1, 0, 32'h0);
    end
    step(1, 0, 0, 0, 32'h0, 0);  want("unstall", 32'h108, 32'h108, 1, 1, 32'h10C);
    step(1, 0, 0, 0, 32'h0, 0);  want("next", 32'h10C, 32'h10C, 1, 1, 32'h110);
    step(1, 1, 1, 0, 32'h0, 0);  want("flush_stall", NOP, 32'h10C, 0, 0, 32'h0);
    step(1, 0, 0, 0, 32'h0, 0);  want("flush_rel", 32'h110, 32'h110, 1, 1, 32'h114);
    step(1, 0, 0, 0, 32'h0, 3);  want("pend", NOP, 32'h110, 0, 1, 32'h114);
    step(0, 0, 0, 0, 32'h0, 0);  want("mid_rst", NOP, 32'h0, 0, 0, 32'h0);
    step(1, 0, 0, 0, 32'h0, 0);  want("reboot", NOP, 32'h0, 0, 1, 32'h0);

    RST2 = 1'b1;
    want2("wrap_boot", NOP, 32'hFFFF_FFF8, 0);        step(1, 0, 0, 0, 32'h0, 0);
    want2("wrap_f8", 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1); step(1, 0, 0, 0, 32'h0, 1);
    want2("wrap_fC", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1); step(1, 0, 0, 0, 32'h0, 0);
    want2("wrap_00", 32'h0, 32'h0, 1);                step(1, 0, 0, 0, 32'h0, 0);

    mem_xor = 32'h1357_9BDF;
    for (int n = 0; n < 4000; n++) begin
      bit r, s, f, b;
      r = ($urandom_range(0, 99) != 0);
      s = ($urandom_range(0, 3) == 0);
      b = ($urandom_range(0, 11) == 0);
      f = b ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 9) == 0);
      step(r, s, f, b, $urandom, $urandom_range(0, 3));
    end
    step(1, 0, 0, 0, 32'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
